alu_exec_unit: RTL and testbench

Parametrised, handshaked ALU execute stage that folds ALU-control decoding and execution into one block. It accepts one operation per transaction, decodes `funct7`/`funct3`/`ALUOp_i` internally, and registers the result. It adds XLEN generalisation, set-less-than ops, an iterative multi-cycle multiplier, and illegal-encoding flagging. It sits between the register-read stage and writeback, with valid/ready flow control on both sides.

---
 rtl/alu_exec_unit_if.sv | 36 +++
 rtl/alu_exec_unit.sv | 187 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Bus bundle for the ALU execute stage: request side from register-read,
// result side towards writeback.
//
// Handshake: both sides use plain valid/ready. A beat transfers on a rising
// clock edge where valid and ready are both high. A producer holding valid
// keeps its payload stable until the transfer. valid never waits on ready.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  // request side
  logic            valid_i;
  logic            ready_o;
  logic [6:0]      funct7_i;
  logic [2:0]      funct3_i;
  logic [1:0]      ALUOp_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  // result side
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            illegal_o;
  logic            valid_o;
  logic            ready_i;

  // upstream/downstream environment
  modport master (
    output valid_i, funct7_i, funct3_i, ALUOp_i, src1_i, src2_i, ready_i,
    input  ready_o, result_o, zero_o, illegal_o, valid_o
  );

  // execute unit
  modport slave (
    input  valid_i, funct7_i, funct3_i, ALUOp_i, src1_i, src2_i, ready_i,
    output ready_o, result_o, zero_o, illegal_o, valid_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute stage: decodes ALUOp/funct7/funct3, runs single-cycle ops
// directly and mul through an iterative shift-add loop, and holds the
// registered result until writeback takes it.
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_exec_unit_if.slave  bus,
  output logic [1:0]      dbg_state_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_ILL
  } op_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  op_e             op;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            ready;
  logic            accept;

  // Reset forces ready low in the same cycle so nothing is taken while resetting.
  assign ready  = (state_q == S_IDLE) && !rst_i;
  assign accept = bus.valid_i && ready;
  assign shamt  = bus.src2_i[SHW-1:0];

  // Decode the instruction fields into one internal operation.
  always_comb begin
    op = OP_ILL;
    case (bus.ALUOp_i)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case ({bus.funct7_i, bus.funct3_i})
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_111: op = OP_AND;
          10'b0000000_110: op = OP_OR;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          10'b0000001_000: op = (MUL_EN != 0) ? OP_MUL : OP_ILL;
          default:         op = OP_ILL;
        endcase
      end
      default: begin
        // I-type: funct7 carries imm[11:5], only inspected for shifts
        case (bus.funct3_i)
          3'b000: op = OP_ADD;
          3'b100: op = OP_XOR;
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b001: op = (bus.funct7_i[6:1] == 6'b000000) ? OP_SLL : OP_ILL;
          default: begin
            if (bus.funct7_i[6:1] == 6'b000000)      op = OP_SRL;
            else if (bus.funct7_i[6:1] == 6'b010000) op = OP_SRA;
            else                                     op = OP_ILL;
          end
        endcase
      end
    endcase
  end

  // Single-cycle datapath; illegal encodings produce zero.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.src1_i + bus.src2_i;
      OP_SUB:  alu_res = bus.src1_i - bus.src2_i;
      OP_AND:  alu_res = bus.src1_i & bus.src2_i;
      OP_OR:   alu_res = bus.src1_i | bus.src2_i;
      OP_XOR:  alu_res = bus.src1_i ^ bus.src2_i;
      OP_SLL:  alu_res = bus.src1_i << shamt;
      OP_SRL:  alu_res = bus.src1_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.src1_i) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.src1_i < bus.src2_i)};
      default: alu_res = '0;
    endcase
  end

  // FSM next state: capture on accept, iterate mul, hold result until taken.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = bus.src1_i;
            mplier_d = bus.src2_i;
            cnt_d    = CNT_INIT;
            state_d  = S_MUL;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (op == OP_ILL);
            state_d   = S_DONE;
          end
        end
      end
      S_MUL: begin
        // One extra cycle at cnt==0 publishes the finished accumulator.
        if (cnt_q == '0) begin
          result_d  = acc_q;
          zero_d    = (acc_q == '0);
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = (state_q == S_DONE);
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;
  assign bus.illegal_o = illegal_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases followed by random operations,
// checked against a behavioural model. A second instance with mul disabled
// sees the same stimulus to exercise the illegal-mul path.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) if0 ();
  alu_exec_unit_if #(.XLEN(XLEN)) if1 ();
  logic [1:0] st0, st1;

  alu_exec_unit #(.XLEN(XLEN), .MUL_EN(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(if0), .dbg_state_o(st0)
  );
  alu_exec_unit #(.XLEN(XLEN), .MUL_EN(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1), .dbg_state_o(st1)
  );

  assign if1.valid_i  = if0.valid_i;
  assign if1.funct7_i = if0.funct7_i;
  assign if1.funct3_i = if0.funct3_i;
  assign if1.ALUOp_i  = if0.ALUOp_i;
  assign if1.src1_i   = if0.src1_i;
  assign if1.src2_i   = if0.src2_i;
  assign if1.ready_i  = if0.ready_i;

  // ---------------- scoreboard state ----------------
  logic [XLEN-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] last_res;
  logic            last_zero;
  logic            last_ill;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_model(
    input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
    input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit mul_en,
    output logic [XLEN-1:0] res, output bit ill, output bit is_mul);
    string op;
    int sh;
    op = "ill";
    if (aluop == 2'd0) op = "add";
    else if (aluop == 2'd1) op = "sub";
    else if (aluop == 2'd2) begin
      if (f7 == 7'd0) begin
        case (f3)
          3'd0: op = "add";  3'd1: op = "sll";  3'd2: op = "slt";  3'd3: op = "sltu";
          3'd4: op = "xor";  3'd5: op = "srl";  3'd6: op = "or";   default: op = "and";
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) op = "sub";
      else if (f7 == 7'h20 && f3 == 3'd5) op = "sra";
      else if (f7 == 7'h01 && f3 == 3'd0 && mul_en) op = "mul";
    end else begin
      case (f3)
        3'd0: op = "add";  3'd2: op = "slt";  3'd3: op = "sltu";
        3'd4: op = "xor";  3'd6: op = "or";   3'd7: op = "and";
        3'd1: if (f7[6:1] == 6'd0) op = "sll";
        default: begin
          if (f7[6:1] == 6'd0) op = "srl";
          else if (f7[6:1] == 6'b010000) op = "sra";
        end
      endcase
    end
    sh = int'(b[4:0]);
    res = '0;
    if (op == "add")       res = a + b;
    else if (op == "sub")  res = a - b;
    else if (op == "and")  res = a & b;
    else if (op == "or")   res = a | b;
    else if (op == "xor")  res = a ^ b;
    else if (op == "sll")  res = a << sh;
    else if (op == "srl")  res = a >> sh;
    else if (op == "sra")  res = $unsigned($signed(a) >>> sh);
    else if (op == "slt")  res = ($signed(a) < $signed(b)) ? 1 : 0;
    else if (op == "sltu") res = (a < b) ? 1 : 0;
    else if (op == "mul")  res = a * b;
    ill = (op == "ill");
    is_mul = (op == "mul");
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int bp);
    logic [XLEN-1:0] e0, e1, exp;
    bit ill0, ill1, m0, m1;
    int lat, rdy_hi;
    ref_model(aluop, f7, f3, a, b, 1'b1, e0, ill0, m0);
    ref_model(aluop, f7, f3, a, b, 1'b0, e1, ill1, m1);
    exp_q.push_back(e0);
    lat = 0;
    while (!if0.ready_o && lat < 100) begin step(); lat++; end
    check("ready_before_accept", if0.ready_o, 1);
    if0.ALUOp_i = aluop; if0.funct7_i = f7; if0.funct3_i = f3;
    if0.src1_i = a; if0.src2_i = b; if0.valid_i = 1'b1;
    step();
    // scramble the inputs: the unit must have captured them at accept
    if0.valid_i = 1'b0;
    if0.src1_i = $urandom(); if0.src2_i = $urandom();
    if0.funct7_i = 7'($urandom()); if0.funct3_i = 3'($urandom());
    check("mul_off_valid", if1.valid_o, 1);
    check("mul_off_result", if1.result_o, e1);
    check("mul_off_zero", if1.zero_o, (e1 == '0));
    check("mul_off_illegal", if1.illegal_o, ill1);
    lat = 0; rdy_hi = 0;
    while (!if0.valid_o && lat < 200) begin
      if (if0.ready_o) rdy_hi++;
      step();
      lat++;
    end
    check("latency", lat, m0 ? (XLEN + 1) : 0);
    check("ready_low_busy", rdy_hi + int'(if0.ready_o), 0);
    exp = exp_q.pop_front();
    check("result", if0.result_o, exp);
    check("zero", if0.zero_o, (exp == '0));
    check("illegal", if0.illegal_o, ill0);
    last_res = if0.result_o; last_zero = if0.zero_o; last_ill = if0.illegal_o;
    for (int k = 0; k < bp; k++) begin
      step();
      check("bp_result_stable", if0.result_o, exp);
      check("bp_valid_ready", {if0.valid_o, if0.ready_o}, 2'b10);
    end
    if0.ready_i = 1'b1;
    step();
    if0.ready_i = 1'b0;
    check("valid_drop", if0.valid_o, 0);
    check("ready_back", if0.ready_o, 1);
  endtask

  function automatic logic [XLEN-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return XLEN'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [9:0] rt [11];
    logic [9:0] enc;
    int spur;
    rt = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_111, 10'b0000000_110,
           10'b0000000_100, 10'b0000000_001, 10'b0000000_101, 10'b0100000_101,
           10'b0000000_010, 10'b0000000_011, 10'b0000001_000};
    if0.valid_i = 1'b0; if0.ready_i = 1'b0; if0.ALUOp_i = 2'd0;
    if0.funct7_i = 7'd0; if0.funct3_i = 3'd0; if0.src1_i = '0; if0.src2_i = '0;

    // reset
    #1;
    check("rst_ready_low", if0.ready_o, 0);
    step(); step();
    check("rst_valid", if0.valid_o, 0);
    check("rst_result", if0.result_o, 0);
    check("rst_zero", if0.zero_o, 0);
    check("rst_illegal", if0.illegal_o, 0);
    check("rst_ready_during", if0.ready_o, 0);
    rst = 1'b0;
    #1;
    check("rst_ready_after", if0.ready_o, 1);

    // directed cases
    run_op(2'd2, 7'h00, 3'd0, 32'd5, 32'd7, 0);
    check("tp_add_res", last_res, 12);
    check("tp_add_zero", last_zero, 0);
    run_op(2'd1, 7'h5a, 3'd6, 32'd9, 32'd9, 0);
    check("tp_sub_res", last_res, 0);
    check("tp_sub_zero", last_zero, 1);
    run_op(2'd3, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 0);
    check("tp_srai", last_res, 32'hF800_0000);
    run_op(2'd3, 7'h00, 3'd5, 32'h8000_0000, 32'd4, 0);
    check("tp_srli", last_res, 32'h0800_0000);
    run_op(2'd2, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 0);
    check("tp_slt", last_res, 1);
    run_op(2'd2, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 0);
    check("tp_sltu", last_res, 0);
    run_op(2'd2, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, 0);
    check("tp_mul", last_res, 32'hFFFF_FFFD);
    run_op(2'd2, 7'h01, 3'd0, 32'h0001_0000, 32'h0001_0000, 0);
    check("tp_mul_wrap_res", last_res, 0);
    check("tp_mul_wrap_zero", last_zero, 1);
    run_op(2'd2, 7'h20, 3'd7, 32'h1234_5678, 32'h0F0F_0F0F, 0);
    check("tp_ill_flag", last_ill, 1);
    check("tp_ill_res", last_res, 0);
    check("tp_ill_zero", last_zero, 1);
    run_op(2'd0, 7'h00, 3'd0, 32'd100, 32'd23, 5);
    run_op(2'd3, 7'h00, 3'd1, 32'h0000_0001, 32'd31, 0);
    check("tp_slli", last_res, 32'h8000_0000);

    // reset in the middle of a mul
    if0.ALUOp_i = 2'd2; if0.funct7_i = 7'h01; if0.funct3_i = 3'd0;
    if0.src1_i = 32'd7; if0.src2_i = 32'd9; if0.valid_i = 1'b1;
    step();
    if0.valid_i = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    step();
    check("midmul_rst_valid", if0.valid_o, 0);
    rst = 1'b0;
    #1;
    check("midmul_rst_ready", if0.ready_o, 1);
    spur = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (if0.valid_o) spur++;
    end
    check("midmul_no_spurious", spur, 0);
    check("midmul_ready_idle", if0.ready_o, 1);

    // random operations
    for (int i = 0; i < 150; i++) begin
      logic [1:0] aluop;
      logic [6:0] f7;
      logic [2:0] f3;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          enc = rt[$urandom_range(0, 10)];
          aluop = 2'd2; f7 = enc[9:3]; f3 = enc[2:0];
        end
        4, 5, 6: begin
          aluop = 2'd3; f3 = 3'($urandom());
          f7 = ($urandom_range(0, 1) == 0) ? 7'(($urandom_range(0, 1) == 0 ? 7'h00 : 7'h20) | 7'($urandom_range(0, 1)))
                                           : 7'($urandom());
        end
        7: begin aluop = 2'($urandom_range(0, 1)); f7 = 7'($urandom()); f3 = 3'($urandom()); end
        default: begin aluop = 2'($urandom()); f7 = 7'($urandom()); f3 = 3'($urandom()); end
      endcase
      run_op(aluop, f7, f3, rand_val(), rand_val(), $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
